flit_injector: RTL
==================

FLIT_INJECTOR -- requirements
Module: flit_injector

Interface
REQ-001 Parameter DATA_W, default 32, flit payload width in bits (min 24).
REQ-002 Parameter DEST_W, default 8, destination address width (DEST_W+12 <= DATA_W).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port pkt_valid  input  1  core offers a packet descriptor.
REQ-006 Port pkt_ready  output  1  injector accepts the descriptor this cycle.
REQ-007 Port pkt_length  input  12  total flits in the packet, header and tail included.
REQ-008 Port pkt_dest  input  DEST_W  destination address.
REQ-009 Port in_valid  input  1  payload word available.
REQ-010 Port in_data  input  DATA_W  payload word.
REQ-011 Port in_ready  output  1  payload word consumed this cycle.
REQ-012 Port req  output  1  request to the router arbiter for this port.
REQ-013 Port grant  input  1  arbiter grant, the one-hot state bit for this port.
REQ-014 Port flit_id  output  3  000 idle, 001 header, 010 body, 100 tail.
REQ-015 Port length  output  12  length of the packet in flight, held constant from header to tail.
REQ-016 Port flit_data  output  DATA_W  flit payload.
REQ-017 Port flit_valid  output  1  flit on flit_id/flit_data is valid.

Function
REQ-018 States: IDLE, HEAD, BODY, TAIL; encoding one-hot.
REQ-019 IDLE: pkt_ready=1; on pkt_valid, latch length and dest and go to HEAD.
REQ-020 A pkt_length below 2 SHALL be latched as 2.
REQ-021 HEAD: flit_id=001; flit_data={zeros, dest, length}; flit_valid=1.
REQ-022 req SHALL be 1 in HEAD, BODY and TAIL, and 0 in IDLE.
REQ-023 A flit transfers only on a cycle with flit_valid=1 and grant=1.
REQ-024 On a header transfer, remaining=length-1, then go to BODY if remaining>1, else to TAIL.
REQ-025 BODY: flit_id=010, flit_data=in_data, flit_valid=in_valid, and in_ready=grant&in_valid.
REQ-026 On each body transfer, decrement remaining; go to TAIL when remaining reaches 1.
REQ-027 TAIL: flit_id=100, flit_data=in_data, flit_valid=in_valid, in_ready=grant&in_valid; on transfer go to IDLE.
REQ-028 Grant loss mid-packet (arbiter timeout): hold state, hold the flit, keep req=1, and resume on regrant without duplicating or dropping a word.
REQ-029 in_valid=0 in BODY or TAIL: flit_valid=0, req stays 1, and no state change.
REQ-030 remaining is 12-bit unsigned and never wraps below 1.
REQ-031 Back-to-back packets: a new descriptor is accepted only in IDLE, so there is at least one idle cycle between tail and next header.
REQ-032 Outputs depend only on state and in_valid/in_data/grant; there is no combinational path from pkt_* to req.

Reset
REQ-033 On rst: state=IDLE, req=0, flit_id=000, flit_valid=0, length=0, remaining=0, pkt_ready=1 after release, in_ready=0.
REQ-034 A reset mid-packet SHALL abandon the packet; unsent payload words are not consumed.

Structure
REQ-035 Shared package noc_pkg SHALL hold the FLIT_HEAD/BODY/TAIL/IDLE constants, the 12-bit length width and the state typedef.
REQ-036 No sub-module; a single always_ff plus one combinational output block.

Verification
REQ-037 length=4, grant=1 constant, and in_valid=1 -> flit_ids 001,010,010,100 on four consecutive cycles, with 3 in_ready pulses.
REQ-038 length=0 -> header, then tail; length output =2; exactly 1 payload word consumed.
REQ-039 length=5, grant dropped for 3 cycles after the second body flit -> req stays 1, the third body flit repeats unchanged until regrant, and there are 4 payload words total.
REQ-040 in_valid low for 2 cycles in BODY -> flit_valid=0 and the state is held; the sequence completes correctly afterwards.
REQ-041 rst asserted asynchronously mid-BODY -> req=0 and flit_id=000 immediately; the next packet starts with header 001.
REQ-042 Two descriptors queued with length=2 each -> tail of the first, one IDLE cycle, then header of the second.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit ids, length width and injector state.
// Imported by the flit injector and its testbench.
package noc_pkg;

    localparam int LEN_W = 12;

    localparam logic [2:0] FLIT_IDLE = 3'b000;
    localparam logic [2:0] FLIT_HEAD = 3'b001;
    localparam logic [2:0] FLIT_BODY = 3'b010;
    localparam logic [2:0] FLIT_TAIL = 3'b100;

    localparam int S_IDLE = 0;
    localparam int S_HEAD = 1;
    localparam int S_BODY = 2;
    localparam int S_TAIL = 3;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_HEAD = 4'b0010,
        ST_BODY = 4'b0100,
        ST_TAIL = 4'b1000
    } inj_state_t;

endpackage

// File: rtl/flit_injector.sv
// Turns a packet descriptor plus a payload stream into header/body/tail
// flits for one router input port, holding each flit until granted.
module flit_injector
    import noc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEST_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic [LEN_W-1:0]  pkt_length,
    input  logic [DEST_W-1:0] pkt_dest,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              req,
    input  logic              grant,
    output logic [2:0]        flit_id,
    output logic [LEN_W-1:0]  length,
    output logic [DATA_W-1:0] flit_data,
    output logic              flit_valid
);

    inj_state_t        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] hdr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            rem_q   <= '0;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            dest_q  <= dest_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rem_d      = rem_q;
        dest_d     = dest_q;
        pkt_ready  = 1'b0;
        in_ready   = 1'b0;
        req        = 1'b0;
        flit_id    = FLIT_IDLE;
        flit_data  = '0;
        flit_valid = 1'b0;
        length     = len_q;
        hdr                   = '0;
        hdr[LEN_W-1:0]        = len_q;
        hdr[LEN_W +: DEST_W]  = dest_q;

        unique case (1'b1)
            state_q[S_IDLE]: begin
                pkt_ready = 1'b1;
                if (pkt_valid) begin
                    // A packet always carries at least header and tail
                    len_d   = (pkt_length < LEN_W'(2)) ? LEN_W'(2) : pkt_length;
                    dest_d  = pkt_dest;
                    state_d = ST_HEAD;
                end
            end
            state_q[S_HEAD]: begin
                req        = 1'b1;
                flit_id    = FLIT_HEAD;
                flit_data  = hdr;
                flit_valid = 1'b1;
                if (grant) begin
                    rem_d   = len_q - LEN_W'(1);
                    state_d = (len_q > LEN_W'(2)) ? ST_BODY : ST_TAIL;
                end
            end
            state_q[S_BODY]: begin
                req        = 1'b1;
                flit_id    = FLIT_BODY;
                flit_data  = in_data;
                flit_valid = in_valid;
                in_ready   = grant & in_valid;
                if (grant && in_valid && rem_q > LEN_W'(1)) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(2)) state_d = ST_TAIL;
                end
            end
            state_q[S_TAIL]: begin
                req        = 1'b1;
                flit_id    = FLIT_TAIL;
                flit_data  = in_data;
                flit_valid = in_valid;
                in_ready   = grant & in_valid;
                if (grant && in_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
